// File: rtl/uart_rx_if.sv
`timescale 1ns/100ps
// CPU-side receive interface of the UART receiver: FIFO head, fill level,
// error flags, and the pop / error-clear strobes.
interface uart_rx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             rx_pop;
  logic             err_clr;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [CNT_W-1:0] rx_count;
  logic             frame_err;
  logic             overrun;

  // Receiver side: consumes the strobes, presents data and status.
  modport slave (
    input  rx_pop,
    input  err_clr,
    output rx_data,
    output rx_valid,
    output rx_count,
    output frame_err,
    output overrun
  );

  // CPU side: issues the strobes, reads data and status.
  modport master (
    output rx_pop,
    output err_clr,
    input  rx_data,
    input  rx_valid,
    input  rx_count,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx.sv
`timescale 1ns/100ps
// 8N1 UART receiver with a fixed baud divisor, a first-word-fall-through
// receive FIFO drained by a pop strobe, and sticky framing/overrun flags.
// All sampling is timed from the detected start edge, so the stop sample
// lands mid stop bit and the FSM is back in IDLE in time for a frame that
// follows immediately.
module uart_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input logic      clk,
  input logic      reset,
  input logic      rx,
  uart_rx_if.slave bus
);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [TMR_W-1:0] BIT_END  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] HALF_END = TMR_W'(HALF - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Line conditioning
  logic s1_r;
  logic s2_r;
  logic s3_r;

  // Deframer
  state_t           state_r;
  logic [TMR_W-1:0] tmr_r;
  logic [2:0]       bit_r;
  logic [7:0]       shift_r;
  logic             tick_s;
  logic             push_s;
  logic             ferr_s;

  // Receive FIFO
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             valid_r;
  logic             pop_ok_s;
  logic             push_ok_s;
  logic             ovr_s;

  // Sticky flags
  logic frame_err_r;
  logic overrun_r;

  // Two-flop synchronizer plus history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r <= 1'b1;
      s2_r <= 1'b1;
      s3_r <= 1'b1;
    end else begin
      s1_r <= rx;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Sample strobe: half a bit into the start bit, then one full bit apart.
  always_comb begin
    tick_s = 1'b0;
    if (state_r == ST_START) begin
      tick_s = (tmr_r == HALF_END);
    end else begin
      tick_s = (tmr_r == BIT_END);
    end
  end

  // Stop-sample outcome: a good byte to store or a framing error.
  always_comb begin
    push_s = 1'b0;
    ferr_s = 1'b0;
    if ((state_r == ST_STOP) && tick_s) begin
      push_s = s2_r;
      ferr_s = ~s2_r;
    end else begin
      push_s = 1'b0;
      ferr_s = 1'b0;
    end
  end

  // Frame sequencer: start detect, start-bit check, 8 data bits LSB first, stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      tmr_r   <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tmr_r <= '0;
          // Only a high-to-low transition starts a frame; a stuck-low line does not.
          if (s3_r && !s2_r) begin
            state_r <= ST_START;
            bit_r   <= 3'd0;
          end
        end
        ST_START: begin
          if (tick_s) begin
            tmr_r <= '0;
            if (s2_r) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_DATA;
              bit_r   <= 3'd0;
            end
          end else begin
            tmr_r <= tmr_r + TMR_W'(1);
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            tmr_r   <= '0;
            shift_r <= {s2_r, shift_r[7:1]};
            if (bit_r == 3'd7) begin
              state_r <= ST_STOP;
            end else begin
              bit_r <= bit_r + 3'd1;
            end
          end else begin
            tmr_r <= tmr_r + TMR_W'(1);
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            tmr_r   <= '0;
            state_r <= ST_IDLE;
          end else begin
            tmr_r <= tmr_r + TMR_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tmr_r   <= '0;
          bit_r   <= 3'd0;
        end
      endcase
    end
  end

  // FIFO admission: pops need data, a push into a full FIFO needs a pop beside it.
  always_comb begin
    pop_ok_s    = bus.rx_pop && valid_r;
    push_ok_s   = push_s && ((count_r != FULL_CNT) || pop_ok_s);
    ovr_s       = push_s && !push_ok_s;
    count_nxt_s = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // FIFO storage array, written at the stop-sample edge.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= shift_r;
    end
  end

  // FIFO pointers and fill level; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != '0);
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= ferr_s | (frame_err_r & ~bus.err_clr);
      overrun_r   <= ovr_s  | (overrun_r   & ~bus.err_clr);
    end
  end

  // Head byte falls through from the array; forced to zero while empty.
  assign bus.rx_data   = valid_r ? mem_r[rd_ptr_r] : 8'h00;
  assign bus.rx_valid  = valid_r;
  assign bus.rx_count  = count_r;
  assign bus.frame_err = frame_err_r;
  assign bus.overrun   = overrun_r;

endmodule
